// File: rtl/dcache_direct_ctrl_if.sv
// Word-serial backing-memory bus between the data cache controller and memory.
// Handshake: the master raises mem_req with mem_wr/mem_addr/mem_wdata and holds them
// stable until the slave pulses mem_ack for one cycle; that cycle transfers the word
// (mem_rdata valid on reads), and the next word may only be requested the cycle after.
interface dcache_direct_ctrl_if;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dcache_direct_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with word-serial
// victim writeback and line fill over dcache_direct_ctrl_if.
module dcache_direct_ctrl #(
  parameter int INDEX_W = 8,
  parameter int WORDS   = 4,
  parameter int TAG_W   = 16 - INDEX_W - 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [1:0]  dbgState,
  dcache_direct_ctrl_if.master mem
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  logic [1:0] cnt;

  logic [TAG_W-1:0] tagMem  [LINES];
  logic [15:0]      dataMem [LINES*WORDS];
  logic [LINES-1:0] validBits;
  logic [LINES-1:0] dirtyBits;

  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic [TAG_W-1:0]   reqTag;
  logic               request;
  logic               illegal;
  logic               lineHit;
  logic [15:0]        rdWord;

  logic                 dataWe;
  logic [INDEX_W+1:0]   dataWaddr;
  logic [15:0]          dataWdata;
  logic                 fillLast;

  assign idx      = Addr[INDEX_W+2:3];
  assign off      = Addr[2:1];
  assign reqTag   = Addr[15:INDEX_W+3];
  assign request  = (Rd ^ Wr) & ~Addr[0];
  assign illegal  = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign lineHit  = validBits[idx] && (tagMem[idx] == reqTag);
  assign rdWord   = dataMem[{idx, off}];
  assign fillLast = (state == FILL) && mem.mem_ack && (cnt == 2'd3);
  assign dbgState = state;

  always_comb begin
    Done          = 1'b0;
    Stall         = 1'b0;
    CacheHit      = 1'b0;
    err           = 1'b0;
    DataOut       = 16'h0000;
    mem.mem_req   = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = 16'h0000;
    mem.mem_wdata = 16'h0000;
    dataWe        = 1'b0;
    dataWaddr     = {idx, off};
    dataWdata     = DataIn;
    unique case (state)
      IDLE: begin
        if (illegal) begin
          err = 1'b1;
        end else if (request) begin
          if (lineHit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = rdWord;
            dataWe   = Wr;
          end else begin
            Stall = 1'b1;
          end
        end
      end
      WB: begin
        Stall         = 1'b1;
        mem.mem_req   = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = {tagMem[idx], idx, cnt, 1'b0};
        mem.mem_wdata = dataMem[{idx, cnt}];
      end
      FILL: begin
        Stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {reqTag, idx, cnt, 1'b0};
        if (mem.mem_ack) begin
          dataWe    = 1'b1;
          dataWaddr = {idx, cnt};
          dataWdata = mem.mem_rdata;
        end
      end
      DONE: begin
        Done   = 1'b1;
        if (Rd) DataOut = rdWord;
        dataWe = Wr;
      end
    endcase
    // Reset forces every output low and blocks array writes, even mid-transfer.
    if (!rst) begin
      Done          = 1'b0;
      Stall         = 1'b0;
      CacheHit      = 1'b0;
      err           = 1'b0;
      DataOut       = 16'h0000;
      mem.mem_req   = 1'b0;
      mem.mem_wr    = 1'b0;
      mem.mem_addr  = 16'h0000;
      mem.mem_wdata = 16'h0000;
      dataWe        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (dataWe) dataMem[dataWaddr] <= dataWdata;
    if (fillLast) tagMem[idx] <= reqTag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      validBits <= '0;
      dirtyBits <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (request && !lineHit) begin
            state <= (validBits[idx] && dirtyBits[idx]) ? WB : FILL;
            cnt   <= 2'd0;
          end else if (request && Wr) begin
            dirtyBits[idx] <= 1'b1;
          end
        end
        WB: begin
          if (mem.mem_ack) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= FILL;
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              validBits[idx] <= 1'b1;
              dirtyBits[idx] <= 1'b0;
              state          <= DONE;
            end
          end
        end
        DONE: begin
          if (Wr) dirtyBits[idx] <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_direct_ctrl.sv
// Directed bench for dcache_direct_ctrl: a latency-programmable backing memory, and
// scoreboard queues for completed accesses and for backing-memory word transfers.
module tb_dcache_direct_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic [1:0]  dbgState;

  dcache_direct_ctrl_if memBus();

  dcache_direct_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .Rd       (Rd),
    .Wr       (Wr),
    .DataOut  (DataOut),
    .Done     (Done),
    .Stall    (Stall),
    .CacheHit (CacheHit),
    .err      (err),
    .dbgState (dbgState),
    .mem      (memBus)
  );

  int checks;
  int failures;
  int ackSeen;
  int ackLat;
  int reqCycles;
  logic [15:0] holdAddr;
  logic        holdWr;

  // {check data, expected CacheHit, expected DataOut}
  logic [17:0] exp_q[$];
  // {mem_wr, mem_addr, mem_wdata (checked on writes only)}
  logic [32:0] memExp_q[$];
  logic [15:0] bmem [int];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (bmem.exists(int'(a))) return bmem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // ---------------- backing memory responder ----------------
  initial begin
    memBus.mem_ack   = 1'b0;
    memBus.mem_rdata = 16'h0000;
    reqCycles = 0;
    forever begin
      @(posedge clk);
      #1;
      if (memBus.mem_ack) begin
        memBus.mem_ack = 1'b0;
        reqCycles = 0;
      end else if (rst && memBus.mem_req) begin
        if (reqCycles == 0) begin
          holdAddr = memBus.mem_addr;
          holdWr   = memBus.mem_wr;
        end else begin
          chk("hold_addr", {16'h0, memBus.mem_addr}, {16'h0, holdAddr});
          chk("hold_wr", {31'h0, memBus.mem_wr}, {31'h0, holdWr});
        end
        reqCycles++;
        if (reqCycles >= ackLat) begin
          memBus.mem_ack = 1'b1;
          if (memBus.mem_wr) bmem[int'(memBus.mem_addr)] = memBus.mem_wdata;
          else memBus.mem_rdata = memRead(memBus.mem_addr);
        end
      end else begin
        reqCycles = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst && memBus.mem_req && memBus.mem_ack) begin
      logic [32:0] e;
      ackSeen++;
      if (memExp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mem_unexpected: got addr %h wr %b, none expected", memBus.mem_addr, memBus.mem_wr);
      end else begin
        e = memExp_q.pop_front();
        chk("mem_wr", {31'h0, memBus.mem_wr}, {31'h0, e[32]});
        chk("mem_addr", {16'h0, memBus.mem_addr}, {16'h0, e[31:16]});
        if (e[32]) chk("mem_wdata", {16'h0, memBus.mem_wdata}, {16'h0, e[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && Done) begin
      logic [17:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected: got Done=1 Addr %h, none expected", Addr);
      end else begin
        e = exp_q.pop_front();
        chk("cache_hit", {31'h0, CacheHit}, {31'h0, e[16]});
        if (e[17]) chk("data_out", {16'h0, DataOut}, {16'h0, e[15:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expReads(input logic [15:0] base);
    for (int i = 0; i < 4; i++) memExp_q.push_back({1'b0, base + 16'(2 * i), 16'h0000});
  endtask

  task automatic expWrites(input logic [15:0] base, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    memExp_q.push_back({1'b1, base, w0});
    memExp_q.push_back({1'b1, base + 16'd2, w1});
    memExp_q.push_back({1'b1, base + 16'd4, w2});
    memExp_q.push_back({1'b1, base + 16'd6, w3});
  endtask

  task automatic doAccess(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    bit stallOk;
    bit seenDone;
    @(posedge clk);
    #2;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    n = 0; stallOk = 1'b1; seenDone = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      if (Done) begin
        seenDone = 1'b1;
        break;
      end
      if (!Stall) stallOk = 1'b0;
      n++;
    end
    chk("done_seen", {31'h0, seenDone}, 32'd1);
    chk("stall_while_pending", {31'h0, stallOk}, 32'd1);
    chk("stall_at_done", {31'h0, Stall}, 32'd0);
    @(posedge clk);
    #2;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic doIllegal(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk);
    #2;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(negedge clk);
    chk("err_set", {31'h0, err}, 32'd1);
    chk("err_stall", {31'h0, Stall}, 32'd0);
    chk("err_done", {31'h0, Done}, 32'd0);
    chk("err_mem_req", {31'h0, memBus.mem_req}, 32'd0);
    @(posedge clk);
    #2;
    Rd = 1'b0; Wr = 1'b0;
    @(negedge clk);
    chk("err_clears", {31'h0, err}, 32'd0);
    chk("err_state_idle", {30'h0, dbgState}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    checks = 0; failures = 0; ackSeen = 0; ackLat = 2;
    rst = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bmem[int'(16'h0010) + 2 * i] = 16'hA000 + 16'(i);
      bmem[int'(16'h0810) + 2 * i] = 16'hB000 + 16'(i);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'h0, Done}, 32'd0);
    chk("rst_stall", {31'h0, Stall}, 32'd0);
    chk("rst_hit", {31'h0, CacheHit}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_mem_req", {31'h0, memBus.mem_req}, 32'd0);
    chk("rst_mem_wr", {31'h0, memBus.mem_wr}, 32'd0);
    chk("rst_mem_addr", {16'h0, memBus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'h0, memBus.mem_wdata}, 32'd0);
    chk("rst_data_out", {16'h0, DataOut}, 32'd0);
    chk("rst_state", {30'h0, dbgState}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // cold read miss
    expReads(16'h0010);
    exp_q.push_back({1'b1, 1'b0, 16'hA000});
    doAccess(1'b1, 1'b0, 16'h0010, 16'h0000);

    // read hit, zero latency, no memory traffic
    exp_q.push_back({1'b1, 1'b1, 16'hA002});
    doAccess(1'b1, 1'b0, 16'h0014, 16'h0000);

    // store hit then conflicting read forces writeback of the dirty line
    exp_q.push_back({1'b0, 1'b1, 16'h0000});
    doAccess(1'b0, 1'b1, 16'h0012, 16'h1234);
    expWrites(16'h0010, 16'hA000, 16'h1234, 16'hA002, 16'hA003);
    expReads(16'h0810);
    exp_q.push_back({1'b1, 1'b0, 16'hB001});
    doAccess(1'b1, 1'b0, 16'h0812, 16'h0000);

    // refetch original line: written-back store data must come back
    expReads(16'h0010);
    exp_q.push_back({1'b1, 1'b0, 16'h1234});
    doAccess(1'b1, 1'b0, 16'h0012, 16'h0000);

    // illegal Rd&Wr on a resident word leaves it untouched
    doIllegal(1'b1, 1'b1, 16'h0014, 16'hDEAD);
    exp_q.push_back({1'b1, 1'b1, 16'hA002});
    doAccess(1'b1, 1'b0, 16'h0014, 16'h0000);

    // illegal requests on 0x0020, which must still miss afterwards
    doIllegal(1'b1, 1'b1, 16'h0020, 16'h5555);
    doIllegal(1'b1, 1'b0, 16'h0021, 16'h0000);
    doIllegal(1'b0, 1'b1, 16'h0023, 16'h7777);
    expReads(16'h0020);
    exp_q.push_back({1'b1, 1'b0, 16'h5A7A});
    doAccess(1'b1, 1'b0, 16'h0020, 16'h0000);

    // store miss allocates, then the dirty line is evicted by a conflict
    expReads(16'h0040);
    exp_q.push_back({1'b0, 1'b0, 16'h0000});
    doAccess(1'b0, 1'b1, 16'h0046, 16'hBEEF);
    exp_q.push_back({1'b1, 1'b1, 16'hBEEF});
    doAccess(1'b1, 1'b0, 16'h0046, 16'h0000);
    expWrites(16'h0040, 16'h5A1A, 16'h5A18, 16'h5A1E, 16'hBEEF);
    expReads(16'h0840);
    exp_q.push_back({1'b1, 1'b0, 16'h521C});
    doAccess(1'b1, 1'b0, 16'h0846, 16'h0000);

    // reset in the middle of a fill
    memExp_q.push_back({1'b0, 16'h0030, 16'h0000});
    memExp_q.push_back({1'b0, 16'h0032, 16'h0000});
    @(posedge clk);
    #2;
    Rd = 1'b1; Addr = 16'h0030;
    base = ackSeen;
    n = 0;
    while (ackSeen < base + 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("midfill_two_acks", 32'(ackSeen - base), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("midfill_req_drop", {31'h0, memBus.mem_req}, 32'd0);
    chk("midfill_state_idle", {30'h0, dbgState}, 32'd0);
    chk("midfill_stall_drop", {31'h0, Stall}, 32'd0);
    Rd = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    expReads(16'h0030);
    exp_q.push_back({1'b1, 1'b0, 16'h5A6A});
    doAccess(1'b1, 1'b0, 16'h0030, 16'h0000);

    // slow memory: request must hold through long ack latency
    ackLat = 5;
    expReads(16'h0050);
    exp_q.push_back({1'b1, 1'b0, 16'h5A0A});
    doAccess(1'b1, 1'b0, 16'h0050, 16'h0000);
    ackLat = 2;

    // idle cycles: nothing requested, nothing happens
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_mem_req", {31'h0, memBus.mem_req}, 32'd0);
    chk("idle_done", {31'h0, Done}, 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("mem_exp_q_empty", 32'(memExp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_direct_ctrl.md
Name: dcache_direct_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller that sits between the memory stage and the backing data memory.
- Services one load or store at a time from the memory stage. Asserts Stall while a miss is in flight, which freezes every pipeline register.
- Holds the tag, valid, dirty and data arrays internally. Line fill and victim writeback use a word-serial request/acknowledge handshake to backing memory.

Parameters:
- INDEX_W, 8, index bits; the cache holds 2^INDEX_W lines.
- WORDS, 4, 16-bit words per line; fixed at 4, so the offset is Addr[2:1].
- TAG_W, 16-INDEX_W-3, tag bits taken from Addr[15:INDEX_W+3].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- Addr  in  16  byte address of the access; Addr[0] must be 0.
- DataIn  in  16  store data.
- Rd  in  1  load request.
- Wr  in  1  store request.
- DataOut  out  16  load data; valid when Done=1 and the request was Rd.
- Done  out  1  access completes this cycle.
- Stall  out  1  pipeline must hold; Addr, DataIn, Rd and Wr stay stable while Stall=1.
- CacheHit  out  1  completed access hit without a fill.
- err  out  1  illegal request: Rd and Wr together, or a misaligned access.
- mem_req  out  1  backing-memory word request.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  16  word-aligned backing address.
- mem_wdata  out  16  writeback data.
- mem_rdata  in  16  fill data; valid with mem_ack on a read.
- mem_ack  in  1  one-cycle pulse; current word accepted or returned.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All valid and dirty bits clear; the word counter clears.
  - Outputs are 0: Done, Stall, CacheHit, err, mem_req, mem_wr, mem_addr, mem_wdata, DataOut.
  - Data and tag arrays are not cleared.
  - Reset mid-miss abandons the transfer; mem_req drops asynchronously.
- Lookup in IDLE, combinational against the registered arrays:
  - Request is Rd^Wr with Addr[0]=0.
  - Hit means valid[idx]=1 and tag[idx]=Addr tag.
- Hit: same cycle Done=1, CacheHit=1, Stall=0.
  - Rd: DataOut = data[idx][off].
  - Wr: at the clock edge, data[idx][off] gets DataIn and dirty[idx] gets 1.
  - Latency is 0 extra cycles.
- Miss: Stall=1 in the request cycle.
  - Next state is WB if valid[idx] and dirty[idx] are both set; otherwise FILL.
- WB:
  - mem_req=1, mem_wr=1, mem_addr={victim tag, idx, cnt, 1'b0}, mem_wdata=data[idx][cnt].
  - cnt advances on each mem_ack. The ack for cnt=3 moves to FILL with cnt=0.
- FILL:
  - mem_req=1, mem_wr=0, mem_addr={req tag, idx, cnt, 1'b0}.
  - On mem_ack, data[idx][cnt] gets mem_rdata.
  - The ack for cnt=3 writes tag[idx], sets valid=1 and dirty=0, then goes to DONE.
- DONE (one cycle):
  - Done=1, CacheHit=0, Stall=0; DataOut comes from the line.
  - A store writes the word and sets dirty.
  - Returns to IDLE.
- Stall is 1 in the miss request cycle and in every WB and FILL cycle. Stall is 0 in IDLE-hit, DONE and idle cycles.
- mem_req stays high and mem_addr stays stable until mem_ack. The controller does not issue back-to-back words in the ack cycle; the next word is requested the following cycle.
- mem_ack outside WB/FILL is ignored.
- Illegal request (Rd&Wr, or Addr[0]=1 with Rd|Wr):
  - err=1 combinationally in that cycle only.
  - No array update, no miss; Done=0, Stall=0.
- No request (Rd=Wr=0): all handshake outputs 0; state unchanged.
- cnt is 2 bits and wraps 3→0 on the last ack.
- mem_ack asserted while mem_req=0 is ignored.

Test Plan:
- Cold read: reset, Rd Addr=0x0010, memory returns 0xA000..0xA003 with 2-cycle ack latency → 4 read requests at 0x0010/12/14/16; Stall high throughout the fill; DONE cycle gives DataOut=0xA000, CacheHit=0.
- Read hit after fill: Rd Addr=0x0014 → same cycle Done=1, CacheHit=1, DataOut=0xA002, no mem_req.
- Store hit then conflicting read: Wr 0x0012 data 0x1234 (hit), then Rd 0x0812 (same index, other tag) → writeback of 4 words to 0x0010..16 with 0x1234 at 0x0012, then fill from 0x0810..16, then Done=1.
- Illegal: Rd=Wr=1 at 0x0020 → err=1 for one cycle, Stall=0, Done=0, arrays unchanged (a later Rd 0x0020 misses). Rd at 0x0021 → err=1.
- Reset mid-fill: deassert rst after the second ack of a fill → mem_req=0 immediately, FSM IDLE; the same Rd then misses and refills all 4 words.
- Hold during stall: delay mem_ack 5 cycles → mem_addr and mem_req stable throughout; no spurious Done.
